// File: rtl/branch_predictor.sv
// IF-stage branch predictor: direct-mapped BTB with 2-bit saturating counters,
// trained by resolved beq/bne outcomes from ID.
module branch_predictor #(
  parameter int unsigned ENTRIES   = 16,
  parameter int unsigned IDX_W     = 4,
  parameter int unsigned ISA_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ISA_WIDTH-1:0] if_pc,
  output logic                 predict_taken,
  output logic [ISA_WIDTH-1:0] predict_target,
  input  logic                 update_valid,
  input  logic [ISA_WIDTH-1:0] update_pc,
  input  logic                 update_taken,
  input  logic [ISA_WIDTH-1:0] update_target,
  input  logic                 update_mispredict,
  output logic [31:0]          branch_count,
  output logic [31:0]          mispredict_count
);

  localparam int unsigned TAG_W = ISA_WIDTH - IDX_W - 2;

  logic [ENTRIES-1:0]   valid_q;
  logic [TAG_W-1:0]     tag_q    [ENTRIES];
  logic [ISA_WIDTH-1:0] target_q [ENTRIES];
  logic [1:0]           ctr_q    [ENTRIES];

  logic [IDX_W-1:0] rd_idx;
  logic [TAG_W-1:0] rd_tag;
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             rd_hit;
  logic             up_hit;
  logic             unused_pc_bits;

  assign rd_idx = if_pc[IDX_W+1:2];
  assign rd_tag = if_pc[ISA_WIDTH-1:IDX_W+2];
  assign up_idx = update_pc[IDX_W+1:2];
  assign up_tag = update_pc[ISA_WIDTH-1:IDX_W+2];
  assign unused_pc_bits = ^{if_pc[1:0], update_pc[1:0]};

  assign rd_hit = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  always_comb begin
    predict_taken  = rd_hit && ctr_q[rd_idx][1];
    predict_target = if_pc + ISA_WIDTH'(4);
    if (predict_taken) predict_target = target_q[rd_idx];
  end

  // Valid bits, counters and statistics carry reset; reset wins over an update.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q          <= '0;
      branch_count     <= '0;
      mispredict_count <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b01;
    end else if (update_valid) begin
      branch_count <= branch_count + 32'd1;
      if (update_mispredict) mispredict_count <= mispredict_count + 32'd1;
      if (up_hit) begin
        if (update_taken) begin
          if (ctr_q[up_idx] != 2'b11) ctr_q[up_idx] <= ctr_q[up_idx] + 2'd1;
        end else begin
          if (ctr_q[up_idx] != 2'b00) ctr_q[up_idx] <= ctr_q[up_idx] - 2'd1;
        end
      end else if (update_taken) begin
        valid_q[up_idx] <= 1'b1;
        ctr_q[up_idx]   <= 2'b10;
      end
    end
  end

  // Tags and targets are unreset storage; valid_q alone qualifies them.
  always_ff @(posedge clk) begin
    if (!rst && update_valid && update_taken) begin
      target_q[up_idx] <= update_target;
      if (!up_hit) tag_q[up_idx] <= up_tag;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus random
// training traffic compared against an array-based reference model.
module tb_branch_predictor;

  localparam int unsigned ENTRIES = 16;
  localparam int unsigned IDX_W   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] if_pc = '0;
  logic        predict_taken;
  logic [31:0] predict_target;
  logic        update_valid = 1'b0;
  logic [31:0] update_pc = '0;
  logic        update_taken = 1'b0;
  logic [31:0] update_target = '0;
  logic        update_mispredict = 1'b0;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Reference model state
  bit          m_valid [ENTRIES];
  logic [31:0] m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];
  logic [31:0] m_bc, m_mc;

  branch_predictor #(.ENTRIES(ENTRIES), .IDX_W(IDX_W), .ISA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc),
    .predict_taken(predict_taken), .predict_target(predict_target),
    .update_valid(update_valid), .update_pc(update_pc),
    .update_taken(update_taken), .update_target(update_target),
    .update_mispredict(update_mispredict),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic int unsigned m_index(input logic [31:0] pc);
    return (pc / 4) % ENTRIES;
  endfunction

  function automatic logic [31:0] m_tagof(input logic [31:0] pc);
    return pc / (4 * ENTRIES);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    int unsigned i = m_index(pc);
    return m_valid[i] && (m_tag[i] == m_tagof(pc));
  endfunction

  function automatic bit m_pred(input logic [31:0] pc);
    return m_hit(pc) && (m_ctr[m_index(pc)] >= 2);
  endfunction

  function automatic logic [31:0] m_target(input logic [31:0] pc);
    logic [31:0] seq;
    seq = pc + 32'd4;
    return m_pred(pc) ? m_tgt[m_index(pc)] : seq;
  endfunction

  task automatic model_edge(input bit r, input bit uv, input logic [31:0] upc,
                            input bit ut, input logic [31:0] utgt, input bit um);
    int unsigned i;
    if (r) begin
      for (int k = 0; k < ENTRIES; k++) begin
        m_valid[k] = 0;
        m_ctr[k]   = 1;
      end
      m_bc = 0;
      m_mc = 0;
    end else if (uv) begin
      i = m_index(upc);
      m_bc = m_bc + 1;
      if (um) m_mc = m_mc + 1;
      if (m_hit(upc)) begin
        if (ut) begin
          m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
          m_tgt[i] = utgt;
        end else begin
          m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
        end
      end else if (ut) begin
        m_valid[i] = 1;
        m_tag[i]   = m_tagof(upc);
        m_tgt[i]   = utgt;
        m_ctr[i]   = 2;
      end
    end
  endtask

  // One clock: drive, compare at the falling edge (pre-update), then clock the model.
  task automatic do_cycle(input logic [31:0] pc, input bit r, input bit uv,
                          input logic [31:0] upc, input bit ut, input logic [31:0] utgt,
                          input bit um, input bit chk, input bit has_exp,
                          input bit exp_t, input logic [31:0] exp_tgt);
    if_pc = pc; rst = r; update_valid = uv; update_pc = upc;
    update_taken = ut; update_target = utgt; update_mispredict = um;
    @(negedge clk);
    if (chk) begin
      check("predict_taken", {31'd0, predict_taken}, {31'd0, m_pred(pc)});
      check("predict_target", predict_target, m_target(pc));
      check("branch_count", branch_count, m_bc);
      check("mispredict_count", mispredict_count, m_mc);
    end
    if (has_exp) begin
      check("exp_taken", {31'd0, predict_taken}, {31'd0, exp_t});
      check("exp_target", predict_target, exp_tgt);
    end
    @(posedge clk);
    model_edge(r, uv, upc, ut, utgt, um);
    #1;
    rst = 1'b0; update_valid = 1'b0; update_mispredict = 1'b0;
  endtask

  task automatic do_reset();
    do_cycle(32'h0, 1, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0, 32'h0);
  endtask

  task automatic upd(input logic [31:0] upc, input bit ut, input logic [31:0] utgt, input bit um);
    do_cycle(32'h0, 0, 1, upc, ut, utgt, um, 1, 0, 0, 32'h0);
  endtask

  task automatic probe(input logic [31:0] pc, input bit exp_t, input logic [31:0] exp_tgt);
    do_cycle(pc, 0, 0, 32'h0, 0, 32'h0, 0, 1, 1, exp_t, exp_tgt);
  endtask

  initial begin
    logic [31:0] pc, upc, tgt;
    @(posedge clk); #1;
    do_reset();

    // Reset state sweep
    for (int unsigned p = 0; p <= 32'h3C; p += 4) probe(p, 0, p + 32'd4);
    check("bc_reset", branch_count, 32'd0);
    check("mc_reset", mispredict_count, 32'd0);

    // Allocate, predict, weaken
    upd(32'h00400010, 1, 32'h00400100, 0);
    probe(32'h00400010, 1, 32'h00400100);
    upd(32'h00400010, 0, 32'h0, 1);
    probe(32'h00400010, 0, 32'h00400014);

    // Saturation both ways
    for (int k = 0; k < 5; k++) upd(32'h00400020, 1, 32'h00400300, 0);
    upd(32'h00400020, 0, 32'h0, 0);
    probe(32'h00400020, 1, 32'h00400300);
    for (int k = 0; k < 4; k++) upd(32'h00400020, 0, 32'h0, 0);
    upd(32'h00400020, 1, 32'h00400300, 0);
    probe(32'h00400020, 0, 32'h00400024);

    // Aliasing: not-taken miss keeps occupant, taken miss evicts it
    upd(32'h00400004, 1, 32'h00400080, 0);
    upd(32'h00400044, 0, 32'h0, 0);
    probe(32'h00400004, 1, 32'h00400080);
    upd(32'h00400044, 1, 32'h00400200, 0);
    probe(32'h00400004, 0, 32'h00400008);
    probe(32'h00400044, 1, 32'h00400200);

    // Same-cycle lookup and update see pre-update contents
    do_reset();
    do_cycle(32'h00400010, 0, 1, 32'h00400010, 1, 32'h00400100, 0, 1, 1, 0, 32'h00400014);
    probe(32'h00400010, 1, 32'h00400100);

    // Statistics
    do_reset();
    for (int k = 0; k < 10; k++)
      upd(32'h00400000 + 32'(k) * 4, k[0], 32'h00401000, (k % 3 == 1));
    check("bc_ten", branch_count, 32'd10);
    check("mc_three", mispredict_count, 32'd3);

    // +4 wrap at top of address space
    probe(32'hFFFFFFFC, 0, 32'h00000000);

    // Reset overrides a concurrent update
    do_cycle(32'h00400010, 1, 1, 32'h00400010, 1, 32'h00400100, 1, 1, 0, 0, 32'h0);
    probe(32'h00400010, 0, 32'h00400014);
    check("bc_after_rst", branch_count, 32'd0);
    check("mc_after_rst", mispredict_count, 32'd0);

    // Random training traffic over a few aliasing tags
    for (int n = 0; n < 600; n++) begin
      pc  = 32'h00400000 + $urandom_range(0, 2) * 64 + $urandom_range(0, 15) * 4 + $urandom_range(0, 3);
      upc = 32'h00400000 + $urandom_range(0, 2) * 64 + $urandom_range(0, 15) * 4 + $urandom_range(0, 3);
      tgt = $urandom;
      if ($urandom_range(0, 19) == 0) pc = 32'hFFFFFFFC;
      if ($urandom_range(0, 3) == 0) upc = pc;
      do_cycle(pc, ($urandom_range(0, 149) == 0), ($urandom_range(0, 3) != 0), upc,
               $urandom_range(0, 1), tgt, $urandom_range(0, 1), 1, 0, 0, 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

IF-stage dynamic branch predictor for the pipelined CPU. It looks up the fetch PC in a direct-mapped branch target buffer (BTB) with 2-bit saturating counters and steers the next fetch. The ID-stage branch condition logic resolves each `beq`/`bne` and returns the outcome, which trains the table. The block is the producing end of the predict/resolve loop whose consuming end is the ID-stage condition check.

## Interface

Parameters:
- `ENTRIES`, default 16: BTB entries, power of two, ≥ 2.
- `IDX_W`, default 4: log2(`ENTRIES`).

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `if_pc`, in, `ISA_WIDTH`: PC currently being fetched.
- `predict_taken`, out, 1: predict the branch at `if_pc` as taken.
- `predict_target`, out, `ISA_WIDTH`: predicted target. Equals `if_pc + 4` when `predict_taken` is 0.
- `update_valid`, in, 1: ID has resolved a conditional branch this cycle.
- `update_pc`, in, `ISA_WIDTH`: PC of the resolved branch.
- `update_taken`, in, 1: resolved condition result (1 = taken).
- `update_target`, in, `ISA_WIDTH`: resolved branch target address.
- `update_mispredict`, in, 1: ID's prediction for this branch was wrong. Qualified by `update_valid`.
- `branch_count`, out, 32: number of accepted updates.
- `mispredict_count`, out, 32: number of accepted updates with `update_mispredict` = 1.

## Operation

- **Index and tag:** index = pc[`IDX_W`+1 : 2]; tag = pc[`ISA_WIDTH`-1 : `IDX_W`+2].
- **Per-entry state:** valid bit, tag, 32-bit target, 2-bit counter `ctr`. Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
- **Lookup (combinational):**
  - hit = valid && tag match.
  - `predict_taken` = hit && `ctr`[1].
  - `predict_target` = stored target if `predict_taken`, else `if_pc + 4`. The +4 wraps modulo 2^32.
- **Update, when `update_valid` = 1, at the rising edge:**
  - Hit, taken: `ctr` increments, saturating at 11; target is overwritten with `update_target`.
  - Hit, not taken: `ctr` decrements, saturating at 00; target is unchanged.
  - Miss, taken: allocate the entry, replacing any occupant. Set valid = 1, write the new tag, target = `update_target`, `ctr` = 10.
  - Miss, not taken: no table change.
- **Statistics:**
  - `branch_count` increments by 1 per accepted update.
  - `mispredict_count` increments by 1 per accepted update with `update_mispredict` = 1.
  - Both wrap from 0xFFFFFFFF to 0.
- `update_valid` = 0: no state changes.
- Unaligned PC bits [1:0] are ignored.

## Timing

- **Reset:** the first rising edge with `rst` = 1 clears every valid bit, sets every `ctr` to 01, and zeros both statistics counters.
  - After reset, `predict_taken` = 0 and `predict_target` = `if_pc + 4`.
  - Tags and targets need no reset.
  - Reset overrides a concurrent update.
  - Reset mid-training discards all history.
- **Lookup latency:** zero cycles. Outputs follow `if_pc` combinationally from the registered table.
- **Update latency:** one cycle. An update at edge N is visible to lookups from edge N onward (i.e. in cycle N+1).
- **Same-cycle lookup and update of the same index:** the lookup returns the pre-update contents. No bypass.
- **Back-to-back updates to the same index on consecutive cycles:** each update sees the previous one's result, so the counter moves one step per cycle.
- **Aliasing:** two PCs with equal index and different tags evict each other, but only on taken-miss allocation. A not-taken miss never evicts.

## Test plan

- **Reset state:** reset, then sweep `if_pc` = 0x00000000 … 0x0000003C → `predict_taken` = 0, `predict_target` = `if_pc + 4`, both counters = 0.
- **Allocate and predict:**
  - Update pc=0x00400010, taken, target=0x00400100 → next cycle `if_pc` = 0x00400010 gives taken and target 0x00400100 (`ctr` = 10).
  - Then one not-taken update → `predict_taken` = 0 (`ctr` = 01).
- **Saturation:**
  - Five taken updates on 0x00400020 → `ctr` = 11. Then one not-taken → still predicted taken.
  - Four not-taken updates → `ctr` = 00. One further taken → still not taken.
- **Aliasing:**
  - Allocate 0x00400004 (taken). Update 0x00400044 not-taken → 0x00400004 still hits.
  - Update 0x00400044 taken, target 0x00400200 → 0x00400004 now misses (not taken); 0x00400044 predicts 0x00400200.
- **Simultaneous read/write:** `if_pc` = `update_pc` = 0x00400010 in the same cycle as its first taken update → that cycle shows not taken; the following cycle shows taken.
- **Statistics and wrap:**
  - 10 updates, 3 flagged mispredict → `branch_count` = 10, `mispredict_count` = 3.
  - `if_pc` = 0xFFFFFFFC on a miss → `predict_target` = 0x00000000.
  - Assert `rst` during an update → both counters = 0 and no allocation occurs.
